// File: rtl/sort_if_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sort_if_pkg
// Description : Shared definitions for the array-sorter job driver.
//               Provides default geometry, the job FSM state encoding and
//               the padding value loaded into unwritten slots.
// Revision    : 1.0 - initial release
// ============================================================================
package sort_if_pkg;

  // Default geometry: 32 slots of 32-bit unsigned elements.
  localparam int ELEM_W_DEF      = 32;
  localparam int N_ELEM_DEF      = 32;
  localparam int TIMEOUT_CYC_DEF = 4096;

  // Job FSM states, named for waveform viewing and shared encoding.
  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    START  = 2'd1,
    WAIT   = 2'd2,
    UNLOAD = 2'd3
  } sort_state_e;

  localparam logic [1:0] ST_LOAD   = 2'(LOAD);
  localparam logic [1:0] ST_START  = 2'(START);
  localparam logic [1:0] ST_WAIT   = 2'(WAIT);
  localparam logic [1:0] ST_UNLOAD = 2'(UNLOAD);

  // Padding is all ones (the maximum unsigned value) so that unused slots
  // always sort behind every real element.
  localparam logic PAD_BIT = 1'b1;
  localparam logic [ELEM_W_DEF-1:0] PAD_VAL = {ELEM_W_DEF{PAD_BIT}};

endpackage : sort_if_pkg
`default_nettype wire

// File: rtl/sort_job_driver.sv
`default_nettype none
// ============================================================================
// Module      : sort_job_driver
// Description : Initiator for the array sorter. Collects a valid/ready element
//               stream into a packed array (unused slots padded with all
//               ones), pulses sort_start, waits for sort_done with a timeout,
//               then replays the first <count> sorted elements as a
//               valid/ready stream.
// Ports       : clk, rst                 clock / async active-high reset
//               s_valid/s_ready/s_data/s_last   input element stream
//               sort_start, sort_done          sorter control
//               sort_data_in, sort_data_out    packed arrays (slot k at
//                                              bits [k*ELEM_W +: ELEM_W])
//               m_valid/m_ready/m_data/m_last  output element stream
//               busy, timeout_err              status
//               order_err                      only with ORDER_CHECK_EN
// Config      : `define ORDER_CHECK_EN adds the sticky order_err output that
//               flags any output element smaller than its predecessor.
// Revision    : 1.0 - initial release
// ============================================================================
module sort_job_driver
  import sort_if_pkg::*;
#(
  parameter int ELEM_W      = ELEM_W_DEF,
  parameter int N_ELEM      = N_ELEM_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [ELEM_W-1:0]        s_data,
  input  logic                     s_last,
  output logic                     sort_start,
  input  logic                     sort_done,
  output logic [N_ELEM*ELEM_W-1:0] sort_data_in,
  input  logic [N_ELEM*ELEM_W-1:0] sort_data_out,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [ELEM_W-1:0]        m_data,
  output logic                     m_last,
  output logic                     busy,
  output logic                     timeout_err
`ifdef ORDER_CHECK_EN
  ,
  output logic                     order_err
`endif
);

  localparam int c_CNT_W = $clog2(N_ELEM + 1);
  localparam int c_TMR_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam bit c_TMO_EN = (TIMEOUT_CYC > 0);
  localparam logic [c_TMR_W-1:0] c_TMR_LAST =
    c_TMR_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
  localparam logic [c_CNT_W-1:0] c_CNT_TOP  = c_CNT_W'(N_ELEM - 1);
  localparam logic [ELEM_W-1:0]  c_PAD      = {ELEM_W{PAD_BIT}};

  logic [1:0]               r_state;
  logic [1:0]               w_state_nxt;
  logic [c_CNT_W-1:0]       r_count;
  logic [c_CNT_W-1:0]       r_idx;
  logic [c_TMR_W-1:0]       r_timer;
  logic                     r_armed;
  logic                     r_s_ready;
  logic                     r_timeout_err;
  logic [N_ELEM*ELEM_W-1:0] r_slots;
  logic [N_ELEM*ELEM_W-1:0] r_result;

  logic w_s_fire;
  logic w_m_fire;
  logic w_load_done;
  logic w_complete;
  logic w_timeout;
  logic w_is_last;
  logic w_unload_done;

  assign w_s_fire      = s_valid & r_s_ready;
  assign w_m_fire      = (r_state == ST_UNLOAD) & m_ready;
  // The final slot closes the job regardless of s_last.
  assign w_load_done   = w_s_fire & (s_last | (r_count == c_CNT_TOP));
  // armed only rises after done has been seen low inside WAIT, so a done
  // level left over from a previous run cannot complete this job.
  assign w_complete    = (r_state == ST_WAIT) & r_armed & sort_done;
  assign w_timeout     = c_TMO_EN & (r_state == ST_WAIT) & ~w_complete &
                         (r_timer == c_TMR_LAST);
  assign w_is_last     = (r_idx == (r_count - c_CNT_ONE));
  assign w_unload_done = w_m_fire & w_is_last;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_LOAD:   if (w_load_done) w_state_nxt = ST_START;
      ST_START:  w_state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (w_complete)     w_state_nxt = ST_UNLOAD;
        else if (w_timeout) w_state_nxt = ST_LOAD;
      end
      ST_UNLOAD: if (w_unload_done) w_state_nxt = ST_LOAD;
      default:   w_state_nxt = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_LOAD;
      r_count   <= '0;
      r_idx     <= '0;
      r_timer   <= '0;
      r_armed   <= 1'b0;
      r_s_ready <= 1'b0;
      r_slots   <= {N_ELEM{c_PAD}};
      r_result  <= '0;
    end else begin
      r_state <= w_state_nxt;
      // Registered so that s_ready stays low while reset is applied.
      r_s_ready <= (w_state_nxt == ST_LOAD);
      case (r_state)
        ST_LOAD: begin
          if (w_s_fire) begin
            r_slots[int'(r_count)*ELEM_W +: ELEM_W] <= s_data;
            r_count <= r_count + c_CNT_ONE;
          end
        end
        ST_START: begin
          r_timer <= '0;
          r_armed <= 1'b0;
        end
        ST_WAIT: begin
          r_timer <= r_timer + c_TMR_W'(1);
          if (!sort_done) r_armed <= 1'b1;
          if (w_complete) begin
            r_result <= sort_data_out;
            r_idx    <= '0;
          end else if (w_timeout) begin
            r_slots <= {N_ELEM{c_PAD}};
            r_count <= '0;
          end
        end
        ST_UNLOAD: begin
          if (w_m_fire) begin
            if (w_is_last) begin
              r_idx   <= '0;
              r_count <= '0;
              r_slots <= {N_ELEM{c_PAD}};
            end else begin
              r_idx <= r_idx + c_CNT_ONE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Sticky until the next element is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            r_timeout_err <= 1'b0;
    else if (w_timeout) r_timeout_err <= 1'b1;
    else if (w_s_fire)  r_timeout_err <= 1'b0;
  end

  assign s_ready      = r_s_ready;
  assign sort_start   = (r_state == ST_START);
  assign sort_data_in = r_slots;
  assign m_valid      = (r_state == ST_UNLOAD);
  // r_idx is returned to 0 at the end of every unload, so the slice
  // always stays in range.
  assign m_data       = r_result[int'(r_idx)*ELEM_W +: ELEM_W];
  assign m_last       = m_valid & w_is_last;
  assign busy         = ~((r_state == ST_LOAD) & (r_count == '0));
  assign timeout_err  = r_timeout_err;

`ifdef ORDER_CHECK_EN
  logic [ELEM_W-1:0] r_prev;
  logic              r_order_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev      <= '0;
      r_order_err <= 1'b0;
    end else begin
      if (w_m_fire) begin
        r_prev <= m_data;
        if ((r_idx != '0) && (m_data < r_prev)) r_order_err <= 1'b1;
      end
      // First accepted element of a new job clears the flag.
      if (w_s_fire && (r_count == '0)) r_order_err <= 1'b0;
    end
  end

  assign order_err = r_order_err;
`endif

endmodule : sort_job_driver
`default_nettype wire
